// File: rtl/ram_block_arbiter_pkg.sv
// rtl/ram_block_arbiter_pkg.sv - shared state encoding and requester indices for the RAM block arbiter
package ram_block_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_OWN   = 3'd2,
    ST_ABORT = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam logic REQ_IMG = 1'b0;
  localparam logic REQ_SD  = 1'b1;

  // Single requester wins outright; on a tie the one that did not win last time goes.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr_last);
    if (v0 && v1) return !rr_last;
    return v1 ? REQ_SD : REQ_IMG;
  endfunction

endpackage

// File: rtl/ram_block_arbiter_if.sv
// rtl/ram_block_arbiter_if.sv - requester and RAM controller signals seen by the block arbiter
interface ram_block_arbiter_if #(
  parameter int BLOCK_W = 8
);
  logic               req0_valid;
  logic [BLOCK_W-1:0] req0_block;
  logic               req0_write;
  logic               req0_abort;
  logic               req0_grant;
  logic               req0_done;

  logic               req1_valid;
  logic [BLOCK_W-1:0] req1_block;
  logic               req1_write;
  logic               req1_abort;
  logic               req1_grant;
  logic               req1_done;

  logic               act;

  logic               ctrl_cmd_valid;
  logic               ctrl_cmd_ready;
  logic [BLOCK_W-1:0] ctrl_cmd_block;
  logic               ctrl_cmd_write;
  logic               ctrl_abort;
  logic               ctrl_done;

  logic               owner;
  logic               timeout_err;

  modport slave (
    input  req0_valid, req0_block, req0_write, req0_abort,
    input  req1_valid, req1_block, req1_write, req1_abort,
    input  act, ctrl_cmd_ready, ctrl_done,
    output req0_grant, req0_done, req1_grant, req1_done,
    output ctrl_cmd_valid, ctrl_cmd_block, ctrl_cmd_write, ctrl_abort,
    output owner, timeout_err
  );

  modport master (
    output req0_valid, req0_block, req0_write, req0_abort,
    output req1_valid, req1_block, req1_write, req1_abort,
    output act, ctrl_cmd_ready, ctrl_done,
    input  req0_grant, req0_done, req1_grant, req1_done,
    input  ctrl_cmd_valid, ctrl_cmd_block, ctrl_cmd_write, ctrl_abort,
    input  owner, timeout_err
  );
endinterface

// File: rtl/ram_block_arbiter_watchdog.sv
// rtl/ram_block_arbiter_watchdog.sv - data-activity watchdog; flags a stalled owner at LIMIT-1 idle cycles
module ram_arb_watchdog #(
  parameter int          WDOG_W     = 16,
  parameter int unsigned WDOG_LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic act_i,
  output logic expire_o
);

  localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Counter only runs while a block is owned; any other state parks it at zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || act_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/ram_block_arbiter.sv
// rtl/ram_block_arbiter.sv - round-robin whole-block owner of the shared SDRAM block controller
module ram_block_arbiter
  import ram_block_arbiter_pkg::*;
#(
  parameter int          BLOCK_W    = 8,
  parameter int          WDOG_W     = 16,
  parameter int unsigned WDOG_LIMIT = 50000
) (
  input  logic                clk,
  input  logic                rst,
  ram_block_arbiter_if.slave  bus
);

  arb_state_e         state_q;
  logic               rr_last_q;
  logic               owner_q;
  logic               grant0_q, grant1_q;
  logic               done0_q, done1_q;
  logic               cmd_valid_q;
  logic               cmd_write_q;
  logic [BLOCK_W-1:0] cmd_block_q;
  logic               ctrl_abort_q;
  logic               timeout_q;

  logic any_valid;
  logic pick;
  logic owner_abort;
  logic wdog_expire;

  assign any_valid   = bus.req0_valid || bus.req1_valid;
  assign pick        = rr_pick(bus.req0_valid, bus.req1_valid, rr_last_q);
  assign owner_abort = (owner_q == REQ_SD) ? bus.req1_abort : bus.req0_abort;

  ram_arb_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == ST_OWN),
    .act_i    (bus.act),
    .expire_o (wdog_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= REQ_SD;
      owner_q      <= REQ_IMG;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_block_q  <= '0;
      ctrl_abort_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      ctrl_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            cmd_block_q <= pick ? bus.req1_block : bus.req0_block;
            cmd_write_q <= pick ? bus.req1_write : bus.req0_write;
            owner_q     <= pick;
            rr_last_q   <= pick;
            grant0_q    <= (pick == REQ_IMG);
            grant1_q    <= (pick == REQ_SD);
            cmd_valid_q <= 1'b1;
            state_q     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.ctrl_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            // Command already accepted, so an abort now must go through the controller.
            if (owner_abort) begin
              ctrl_abort_q <= 1'b1;
              state_q      <= ST_ABORT;
            end else begin
              state_q <= ST_OWN;
            end
          end else if (owner_abort) begin
            cmd_valid_q <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            done0_q     <= (owner_q == REQ_IMG);
            done1_q     <= (owner_q == REQ_SD);
            state_q     <= ST_GAP;
          end
        end
        ST_OWN: begin
          if (bus.ctrl_done) begin
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= (owner_q == REQ_IMG);
            done1_q  <= (owner_q == REQ_SD);
            state_q  <= ST_GAP;
          end else if (owner_abort || wdog_expire) begin
            ctrl_abort_q <= 1'b1;
            if (wdog_expire) timeout_q <= 1'b1;
            state_q <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (bus.ctrl_done) begin
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= (owner_q == REQ_IMG);
            done1_q  <= (owner_q == REQ_SD);
            state_q  <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_grant     = grant0_q;
  assign bus.req1_grant     = grant1_q;
  assign bus.req0_done      = done0_q;
  assign bus.req1_done      = done1_q;
  assign bus.ctrl_cmd_valid = cmd_valid_q;
  assign bus.ctrl_cmd_block = cmd_block_q;
  assign bus.ctrl_cmd_write = cmd_write_q;
  assign bus.ctrl_abort     = ctrl_abort_q;
  assign bus.owner          = owner_q;
  assign bus.timeout_err    = timeout_q;

endmodule

// File: tb/tb_ram_block_arbiter.sv
// tb/tb_ram_block_arbiter.sv - self-checking bench for ram_block_arbiter
module tb_ram_block_arbiter;

  logic clk;
  logic rst;

  ram_block_arbiter_if #(.BLOCK_W(8)) bus ();

  ram_block_arbiter #(
    .BLOCK_W    (8),
    .WDOG_W     (16),
    .WDOG_LIMIT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: g0 g1 d0 d1 cmd_valid cmd_write ctrl_abort owner timeout | cmd_block[7:0]
  logic [16:0] outs;
  assign outs = {bus.req0_grant, bus.req1_grant, bus.req0_done, bus.req1_done,
                 bus.ctrl_cmd_valid, bus.ctrl_cmd_write, bus.ctrl_abort, bus.owner,
                 bus.timeout_err, bus.ctrl_cmd_block};

  typedef struct {
    logic [6:0]  in_bits;   // v0 a0 v1 a1 act rdy done
    logic [7:0]  b0;
    logic        w0;
    logic [7:0]  b1;
    logic        w1;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t V(input logic [6:0] in_bits, input logic [7:0] b0, input logic w0,
                             input logic [7:0] b1, input logic w1,
                             input logic [8:0] ctl, input logic [7:0] blk);
    vec_t v;
    v.in_bits = in_bits;
    v.b0 = b0; v.w0 = w0; v.b1 = b1; v.w1 = w1;
    v.exp = {ctl, blk};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_block = 0; bus.req0_write = 0; bus.req0_abort = 0;
    bus.req1_valid = 0; bus.req1_block = 0; bus.req1_write = 0; bus.req1_abort = 0;
    bus.act = 0; bus.ctrl_cmd_ready = 0; bus.ctrl_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    logic abort_seen;

    rst = 1'b1;
    clear_inputs();
    tick();
    chk("reset_outputs", 32'(outs), 32'h0);
    tick();
    rst = 1'b0;

    // Single img block, abort-in-CMD, done-beats-abort, owner abort in OWN
    vq.push_back(V(7'b1000_010, 8'h12, 1, 8'h00, 0, 9'b1_0_0_0_1_1_0_0_0, 8'h12));
    vq.push_back(V(7'b0000_010, 8'h00, 0, 8'h00, 0, 9'b1_0_0_0_0_1_0_0_0, 8'h12));
    for (int i = 0; i < 9; i++)
      vq.push_back(V(7'b0000_100, 8'h00, 0, 8'h00, 0, 9'b1_0_0_0_0_1_0_0_0, 8'h12));
    vq.push_back(V(7'b0000_001, 8'h00, 0, 8'h00, 0, 9'b0_0_1_0_0_1_0_0_0, 8'h12));
    vq.push_back(V(7'b0000_000, 8'h00, 0, 8'h00, 0, 9'b0_0_0_0_0_1_0_0_0, 8'h12));
    vq.push_back(V(7'b1001_000, 8'h34, 0, 8'h00, 0, 9'b1_0_0_0_1_0_0_0_0, 8'h34));
    vq.push_back(V(7'b0001_000, 8'h00, 0, 8'h00, 0, 9'b1_0_0_0_1_0_0_0_0, 8'h34));
    vq.push_back(V(7'b0100_000, 8'h00, 0, 8'h00, 0, 9'b0_0_1_0_0_0_0_0_0, 8'h34));
    vq.push_back(V(7'b0000_000, 8'h00, 0, 8'h00, 0, 9'b0_0_0_0_0_0_0_0_0, 8'h34));
    vq.push_back(V(7'b0010_010, 8'h00, 0, 8'h56, 1, 9'b0_1_0_0_1_1_0_1_0, 8'h56));
    vq.push_back(V(7'b0100_010, 8'h00, 0, 8'h00, 0, 9'b0_1_0_0_0_1_0_1_0, 8'h56));
    vq.push_back(V(7'b0001_001, 8'h00, 0, 8'h00, 0, 9'b0_0_0_1_0_1_0_1_0, 8'h56));
    vq.push_back(V(7'b0000_000, 8'h00, 0, 8'h00, 0, 9'b0_0_0_0_0_1_0_1_0, 8'h56));
    vq.push_back(V(7'b0010_010, 8'h00, 0, 8'h78, 0, 9'b0_1_0_0_1_0_0_1_0, 8'h78));
    vq.push_back(V(7'b0000_010, 8'h00, 0, 8'h00, 0, 9'b0_1_0_0_0_0_0_1_0, 8'h78));
    vq.push_back(V(7'b0001_000, 8'h00, 0, 8'h00, 0, 9'b0_1_0_0_0_0_1_1_0, 8'h78));
    vq.push_back(V(7'b0001_000, 8'h00, 0, 8'h00, 0, 9'b0_1_0_0_0_0_0_1_0, 8'h78));
    vq.push_back(V(7'b0000_001, 8'h00, 0, 8'h00, 0, 9'b0_0_0_1_0_0_0_1_0, 8'h78));
    vq.push_back(V(7'b0000_000, 8'h00, 0, 8'h00, 0, 9'b0_0_0_0_0_0_0_1_0, 8'h78));

    for (int i = 0; i < vq.size(); i++) begin
      {bus.req0_valid, bus.req0_abort, bus.req1_valid, bus.req1_abort,
       bus.act, bus.ctrl_cmd_ready, bus.ctrl_done} = vq[i].in_bits;
      bus.req0_block = vq[i].b0; bus.req0_write = vq[i].w0;
      bus.req1_block = vq[i].b1; bus.req1_write = vq[i].w1;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vq[i].exp));
    end
    clear_inputs();

    // Round robin with both requesters held valid from reset
    do_reset();
    bus.req0_valid = 1; bus.req0_block = 8'hA0;
    bus.req1_valid = 1; bus.req1_block = 8'hB1;
    bus.ctrl_cmd_ready = 1;
    for (int blk = 0; blk < 3; blk++) begin
      waited = 0;
      while (!(bus.req0_grant || bus.req1_grant) && waited < 8) begin
        tick();
        waited++;
      end
      chk("rr_grant_wait", 32'(bus.req0_grant || bus.req1_grant), 32'd1);
      chk($sformatf("rr_grants%0d", blk), 32'({bus.req0_grant, bus.req1_grant}),
          (blk % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("rr_owner%0d", blk), 32'(bus.owner), 32'(blk % 2));
      if (blk > 0) chk($sformatf("rr_release_to_grant%0d", blk), 32'(waited), 32'd2);
      tick();
      chk("rr_cmd_taken", 32'(bus.ctrl_cmd_valid), 32'd0);
      bus.ctrl_done = 1;
      tick();
      bus.ctrl_done = 0;
      chk($sformatf("rr_done%0d", blk), 32'({bus.req0_grant, bus.req1_grant, bus.req0_done, bus.req1_done}),
          (blk % 2 == 0) ? 32'b0010 : 32'b0001);
    end
    clear_inputs();

    // Watchdog expiry with owner 1 and no data activity
    do_reset();
    bus.req1_valid = 1; bus.req1_block = 8'h9C; bus.req1_write = 1;
    bus.ctrl_cmd_ready = 1;
    tick();
    bus.req1_valid = 0;
    tick();
    chk("wd_in_own", 32'({bus.req1_grant, bus.ctrl_cmd_valid}), 32'b10);
    abort_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      abort_seen = abort_seen | bus.ctrl_abort;
    end
    chk("wd_early_abort", 32'(abort_seen), 32'd0);
    tick();
    chk("wd_abort_fire", 32'({bus.ctrl_abort, bus.timeout_err, bus.req1_grant}), 32'b111);
    tick();
    chk("wd_abort_pulse_width", 32'({bus.ctrl_abort, bus.timeout_err, bus.req1_grant}), 32'b011);
    tick();
    tick();
    chk("wd_grant_held", 32'({bus.req1_grant, bus.req1_done}), 32'b10);
    bus.ctrl_done = 1;
    tick();
    bus.ctrl_done = 0;
    chk("wd_release", 32'({bus.req1_grant, bus.req1_done, bus.timeout_err}), 32'b011);
    tick();
    chk("wd_sticky", 32'({bus.req1_done, bus.timeout_err}), 32'b01);

    // Asynchronous reset in the middle of an owned block
    bus.req1_valid = 1; bus.req1_block = 8'h11;
    bus.ctrl_cmd_ready = 1;
    tick();
    bus.req1_valid = 0;
    tick();
    chk("rst_pre_own", 32'({bus.req1_grant, bus.owner}), 32'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'(outs), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req0_valid = 1; bus.req0_block = 8'h21;
    bus.req1_valid = 1; bus.req1_block = 8'h22;
    tick();
    chk("rst_favours_req0", 32'({bus.req0_grant, bus.req1_grant, bus.owner}), 32'b100);
    chk("rst_block", 32'(bus.ctrl_cmd_block), 32'h21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_block_arbiter.md
Name: ram_block_arbiter

Overview:
Shares the single SDRAM block controller between two requesters: image capture (req0, writes) and SD readout (req1, reads/writes). Grants whole-block ownership with round-robin fairness, issues the block command to the RAM controller, and holds the grant until the controller reports completion. A data-activity watchdog aborts a stalled owner. Sits between the Img/SDWrite datapaths and the RAM controller inside ICEApp.

Parameters:
BLOCK_W, 8, width of block index sent to RAM controller
WDOG_W, 16, width of watchdog counter
WDOG_LIMIT, 16'd50000, idle cycles before forced abort (must be >0)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  img requester wants a block; held until grant
req0_block  in  BLOCK_W  block index, sampled at grant
req0_write  in  1  1=write, 0=read, sampled at grant
req0_abort  in  1  owner-requested abort (ignored unless owner=0)
req0_grant  out  1  high while req0 owns the RAM
req0_done  out  1  1-cycle pulse when req0 ownership ends
req1_valid / req1_block / req1_write / req1_abort / req1_grant / req1_done  same as req0 for SD requester
act  in  1  data-beat strobe from current owner; clears watchdog
ctrl_cmd_valid  out  1  block command valid
ctrl_cmd_ready  in  1  controller accepts command when valid&ready
ctrl_cmd_block  out  BLOCK_W  latched block index
ctrl_cmd_write  out  1  latched direction
ctrl_abort  out  1  1-cycle pulse requesting controller abort
ctrl_done  in  1  1-cycle pulse: block finished or abort complete
owner  out  1  index of current/last owner (data mux select)
timeout_err  out  1  sticky; set on watchdog abort, cleared only by rst

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, rr_last=1 (so req0 wins first tie), watchdog=0.
- States: IDLE, CMD, OWN, ABORT, GAP.
- IDLE: if exactly one valid, pick it; if both, pick !rr_last. On pick: latch block/write, owner<=pick, grant for pick <=1, rr_last<=pick, -> CMD next cycle. Grant rises 1 cycle after valid seen.
- CMD: ctrl_cmd_valid=1, block/write stable. On ctrl_cmd_ready -> OWN (valid drops next cycle). Abort or watchdog in CMD: drop cmd_valid, -> GAP directly (controller never started), done pulse for owner.
- OWN: watchdog increments each cycle, resets to 0 on act. On ctrl_done -> GAP. On reqN_abort (N=owner) or watchdog==WDOG_LIMIT-1 -> ctrl_abort pulse 1 cycle, -> ABORT; watchdog expiry also sets timeout_err.
- ctrl_done and abort in same cycle: ctrl_done wins, no ctrl_abort issued.
- ABORT: wait ctrl_done -> GAP. Further aborts ignored.
- GAP: one cycle; grant drops, reqN_done pulses for owner, watchdog cleared -> IDLE. Guarantees ≥1 idle cycle between owners so data mux switch is glitch-free.
- owner holds last value after release.
- req_valid dropping while granted is ignored; release only via done/abort.
- Minimum cycle count per block: IDLE→CMD 1, CMD≥1, OWN≥1, GAP 1.
- Non-owner abort inputs ignored in all states.

Decomposition:
- Shared package: state encoding constants, requester index constants (REQ_IMG=0, REQ_SD=1).
- One natural sub-module: ram_arb_watchdog (counter, clear on act, expiry flag at LIMIT-1, enable only in OWN).

Test Plan:
- req0_valid alone, block=0x12 write=1, ready same cycle, ctrl_done 10 cycles later -> grant0 next cycle, cmd_block=0x12/write=1 one cycle, done0 pulse in GAP, owner=0.
- req0 and req1 both valid from reset for 3 back-to-back blocks -> grants alternate 0,1,0 with exactly one idle GAP cycle between.
- Owner 1, act never asserted, WDOG_LIMIT=8 -> ctrl_abort pulse on 8th OWN cycle, timeout_err=1 sticky, grant1 held until ctrl_done, then done1.
- req0_abort in OWN same cycle as ctrl_done -> no ctrl_abort, normal release, timeout_err=0.
- req1_abort asserted while owner=0 -> ignored; req0_abort during CMD before ready -> cmd_valid drops, no ctrl_abort, done0 pulse.
- Assert rst mid-OWN -> all outputs 0 immediately, next arbitration favours req0.
